// File: rtl/spi_minion_arbiter.sv
// Routes SPI minion messages to N_PORTS clients by address and round-robin merges their
// responses back into the minion. Define SPI_ARB_DROP_CNT_EN to count dropped bad-address messages.

module spi_arb_lane #(
  parameter int PAYLOAD_W = 30,
  parameter int ADDR_W    = 2,
  parameter int IDX       = 0
) (
  input  logic                 dn_full,
  input  logic [ADDR_W-1:0]    dn_addr,
  input  logic [PAYLOAD_W-1:0] dn_payload,
  output logic                 out_val,
  output logic [PAYLOAD_W-1:0] out_msg
);
  assign out_val = dn_full && (dn_addr == ADDR_W'(IDX));
  assign out_msg = dn_payload;
endmodule

module spi_minion_arbiter #(
  parameter  int BIT_WIDTH = 32,
  parameter  int N_PORTS   = 4,
  localparam int ADDR_W    = $clog2(N_PORTS),
  localparam int PAYLOAD_W = BIT_WIDTH - ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           spi_msg,
  input  logic                           spi_val,
  output logic                           spi_rdy,
  output logic [BIT_WIDTH-1:0]           resp_msg,
  output logic                           resp_val,
  input  logic                           resp_rdy,
  output logic [N_PORTS*PAYLOAD_W-1:0]   out_msg,
  output logic [N_PORTS-1:0]             out_val,
  input  logic [N_PORTS-1:0]             out_rdy,
  input  logic [N_PORTS*PAYLOAD_W-1:0]   in_msg,
  input  logic [N_PORTS-1:0]             in_val,
  output logic [N_PORTS-1:0]             in_rdy,
  output logic [7:0]                     drop_cnt
);

  // ---------------- downstream ----------------
  logic                 dn_full;
  logic [ADDR_W-1:0]    dn_addr;
  logic [PAYLOAD_W-1:0] dn_payload;
  logic [ADDR_W-1:0]    spi_addr;
  logic                 bad_addr, drain, accept;

  assign spi_addr = spi_msg[BIT_WIDTH-1 -: ADDR_W];
  assign bad_addr = 32'(spi_addr) >= 32'(N_PORTS);
  assign drain    = |(out_val & out_rdy);
  assign spi_rdy  = !dn_full || drain;
  assign accept   = spi_val && spi_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      dn_full <= 1'b0;
    end else if (accept && !bad_addr) begin
      dn_full    <= 1'b1;
      dn_addr    <= spi_addr;
      dn_payload <= spi_msg[PAYLOAD_W-1:0];
    end else if (drain) begin
      dn_full <= 1'b0;
    end
  end

`ifdef SPI_ARB_DROP_CNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk) begin
    if (reset)
      drop_q <= '0;
    else if (accept && bad_addr && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    spi_arb_lane #(.PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .IDX(i)) u_lane (
      .dn_full    (dn_full),
      .dn_addr    (dn_addr),
      .dn_payload (dn_payload),
      .out_val    (out_val[i]),
      .out_msg    (out_msg[i*PAYLOAD_W +: PAYLOAD_W])
    );
  end

  // ---------------- upstream ----------------
  typedef enum logic {IDLE, SEND} up_state_t;
  up_state_t            state, state_nxt;
  logic [ADDR_W-1:0]    rr_ptr, gnt, resp_gnt;
  logic                 gnt_vld;
  logic [PAYLOAD_W-1:0] gnt_payload;

  // Winner is the requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    int best_d, d;
    gnt         = rr_ptr;
    gnt_vld     = 1'b0;
    gnt_payload = '0;
    best_d      = N_PORTS;
    d           = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + N_PORTS - int'(rr_ptr);
      if (in_val[i] && d < best_d) begin
        best_d      = d;
        gnt         = ADDR_W'(i);
        gnt_vld     = 1'b1;
        gnt_payload = in_msg[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = '0;
    resp_val  = 1'b0;
    case (state)
      IDLE: if (gnt_vld) begin
        for (int i = 0; i < N_PORTS; i++) in_rdy[i] = (gnt == ADDR_W'(i));
        state_nxt = SEND;
      end
      SEND: begin
        resp_val = 1'b1;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == SEND && resp_rdy)
        rr_ptr <= (resp_gnt == ADDR_W'(N_PORTS-1)) ? '0 : resp_gnt + 1'b1;
    end
  end

  // Response register only loads on a grant, so it holds while the minion stalls.
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_vld) begin
      resp_msg <= {gnt, gnt_payload};
      resp_gnt <= gnt;
    end
  end

endmodule

// File: tb/tb_spi_minion_arbiter.sv
// Bench for spi_minion_arbiter: vector table, directed corner sequences, and a random run
// against a queue-based reference model; a second N_PORTS=3 instance covers bad addresses.

module tb_spi_minion_arbiter;
  localparam int BW = 32, N = 4, PW = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW-1:0]     spi_msg;
  logic              spi_val, spi_rdy;
  logic [BW-1:0]     resp_msg;
  logic              resp_val, resp_rdy;
  logic [N*PW-1:0]   out_msg, in_msg;
  logic [N-1:0]      out_val, out_rdy, in_val, in_rdy;
  logic [7:0]        drop_cnt;

  logic [BW-1:0]     spi3_msg;
  logic              spi3_val, spi3_rdy;
  logic [BW-1:0]     resp3_msg;
  logic              resp3_val;
  logic              resp3_rdy = 1'b1;
  logic [3*PW-1:0]   out3_msg;
  logic [3*PW-1:0]   in3_msg = '0;
  logic [2:0]        out3_val, in3_rdy;
  logic [2:0]        out3_rdy = 3'b111;
  logic [2:0]        in3_val = 3'b000;
  logic [7:0]        drop3_cnt;

  always #5 clk = ~clk;

  spi_minion_arbiter #(.BIT_WIDTH(BW), .N_PORTS(N)) dut (
    .clk(clk), .reset(reset), .spi_msg(spi_msg), .spi_val(spi_val), .spi_rdy(spi_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
    .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy), .drop_cnt(drop_cnt));

  spi_minion_arbiter #(.BIT_WIDTH(BW), .N_PORTS(3)) dut3 (
    .clk(clk), .reset(reset), .spi_msg(spi3_msg), .spi_val(spi3_val), .spi_rdy(spi3_rdy),
    .resp_msg(resp3_msg), .resp_val(resp3_val), .resp_rdy(resp3_rdy),
    .out_msg(out3_msg), .out_val(out3_val), .out_rdy(out3_rdy),
    .in_msg(in3_msg), .in_val(in3_val), .in_rdy(in3_rdy), .drop_cnt(drop3_cnt));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  typedef struct {
    logic [31:0] msg;
    logic [3:0]  exp_val;
    logic [29:0] exp_pl;
  } dn_vec_t;

  dn_vec_t     vecs [5];
  logic [31:0] dq [$];
  logic [31:0] pq [$];
  logic [31:0] e_resp;
  logic [7:0]  exp_drop;
  int          rr, g, idx, a, e;
  logic        found, e_spi_rdy;

  initial begin
    vecs[0] = '{32'h8000_00AB, 4'b0100, 30'h0000_00AB};
    vecs[1] = '{32'h0000_0001, 4'b0001, 30'h0000_0001};
    vecs[2] = '{32'h4123_4567, 4'b0010, 30'h0123_4567};
    vecs[3] = '{32'hFFFF_FFFF, 4'b1000, 30'h3FFF_FFFF};
    vecs[4] = '{32'hBFFF_0000, 4'b0100, 30'h3FFF_0000};

    reset = 1'b1; spi_msg = '0; spi_val = 1'b0; resp_rdy = 1'b0;
    out_rdy = '1; in_msg = '0; in_val = '0; spi3_msg = '0; spi3_val = 1'b0;
    tick; tick;
    reset = 1'b0;
    settle;
    chk("rst_spi_rdy", 64'(spi_rdy), 64'd1);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // single messages, one per vector, each drained the cycle it appears
    for (int i = 0; i < 5; i++) begin
      spi_msg = vecs[i].msg; spi_val = 1'b1;
      settle;
      chk("vec_spi_rdy", 64'(spi_rdy), 64'd1);
      tick;
      spi_val = 1'b0;
      settle;
      chk("vec_out_val", 64'(out_val), 64'(vecs[i].exp_val));
      a = int'(vecs[i].msg[31:30]);
      chk("vec_payload", 64'(out_msg[a*PW +: PW]), 64'(vecs[i].exp_pl));
      tick;
      settle;
      chk("vec_drained", 64'(out_val), 64'd0);
    end

    // all clients requesting: strict rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) in_msg[i*PW +: PW] = 30'h100 + 30'(i);
    in_val = 4'hF; resp_rdy = 1'b1; e = 0;
    repeat (5) begin
      settle;
      chk("rr_in_rdy", 64'(in_rdy), 64'(4'b1 << e));
      tick;
      settle;
      chk("rr_resp_val", 64'(resp_val), 64'd1);
      chk("rr_in_rdy_send", 64'(in_rdy), 64'd0);
      chk("rr_resp_msg", 64'(resp_msg), 64'({2'(e), 30'h100 + 30'(e)}));
      tick;
      e = (e + 1) % N;
    end
    in_val = '0;

    // port 1 stalled: second message backs up, then both drain in order
    out_rdy = 4'b1101; spi_msg = 32'h4000_0AAA; spi_val = 1'b1;
    settle;
    chk("bp_spi_rdy0", 64'(spi_rdy), 64'd1);
    tick;
    spi_msg = 32'h4000_0BBB;
    settle;
    chk("bp_out_val", 64'(out_val), 64'h2);
    chk("bp_spi_rdy1", 64'(spi_rdy), 64'd0);
    tick;
    settle;
    chk("bp_spi_rdy2", 64'(spi_rdy), 64'd0);
    chk("bp_first", 64'(out_msg[PW +: PW]), 64'h0AAA);
    out_rdy = 4'hF;
    settle;
    chk("bp_spi_rdy3", 64'(spi_rdy), 64'd1);
    tick;
    spi_val = 1'b0;
    settle;
    chk("bp_second_val", 64'(out_val), 64'h2);
    chk("bp_second", 64'(out_msg[PW +: PW]), 64'h0BBB);
    tick;
    settle;
    chk("bp_empty", 64'(out_val), 64'd0);

    // stalled response (rr_ptr is 1 here, so port 2 wins)
    in_val = 4'b0100; in_msg[2*PW +: PW] = 30'h2222; resp_rdy = 1'b0;
    settle;
    chk("stall_grant", 64'(in_rdy), 64'h4);
    tick;
    in_val = 4'hF; in_msg[2*PW +: PW] = 30'h3333;
    repeat (5) begin
      settle;
      chk("stall_resp_val", 64'(resp_val), 64'd1);
      chk("stall_in_rdy", 64'(in_rdy), 64'd0);
      chk("stall_resp_msg", 64'(resp_msg), 64'({2'd2, 30'h2222}));
      tick;
    end
    resp_rdy = 1'b1;
    tick;
    resp_rdy = 1'b0;
    settle;
    chk("stall_rr_next", 64'(in_rdy), 64'h8);

    // reset while downstream full and upstream in SEND
    out_rdy = '0; spi_msg = 32'hC000_0001; spi_val = 1'b1;
    tick;
    spi_val = 1'b0; in_val = '0;
    settle;
    chk("mid_out_val", 64'(out_val), 64'h8);
    chk("mid_resp_val", 64'(resp_val), 64'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    settle;
    chk("mrst_out_val", 64'(out_val), 64'd0);
    chk("mrst_resp_val", 64'(resp_val), 64'd0);
    chk("mrst_spi_rdy", 64'(spi_rdy), 64'd1);
    in_val = 4'hF;
    settle;
    chk("mrst_rr_ptr", 64'(in_rdy), 64'h1);
    in_val = '0; out_rdy = '1;
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // random traffic against a queue model
    rr = 0; dq.delete(); pq.delete();
    for (int c = 0; c < 400; c++) begin
      spi_val  = 1'($urandom_range(0, 1));
      spi_msg  = $urandom();
      out_rdy  = 4'($urandom());
      in_val   = 4'($urandom());
      resp_rdy = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) in_msg[i*PW +: PW] = 30'($urandom());
      settle;
      e_spi_rdy = (dq.size() == 0) || out_rdy[dq[0][31:30]];
      chk("rnd_spi_rdy", 64'(spi_rdy), 64'(e_spi_rdy));
      if (dq.size() != 0) begin
        a = int'(dq[0][31:30]);
        chk("rnd_out_val", 64'(out_val), 64'(4'b1 << a));
        chk("rnd_out_msg", 64'(out_msg[a*PW +: PW]), 64'(dq[0][29:0]));
      end else begin
        chk("rnd_out_val", 64'(out_val), 64'd0);
      end
      found = 1'b0; g = 0;
      if (pq.size() == 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (!found && in_val[idx]) begin found = 1'b1; g = idx; end
        end
        chk("rnd_resp_val", 64'(resp_val), 64'd0);
        chk("rnd_in_rdy", 64'(in_rdy), found ? 64'(4'b1 << g) : 64'd0);
      end else begin
        chk("rnd_resp_val", 64'(resp_val), 64'd1);
        chk("rnd_in_rdy", 64'(in_rdy), 64'd0);
        chk("rnd_resp_msg", 64'(resp_msg), 64'(pq[0]));
      end
      if (dq.size() != 0 && out_rdy[dq[0][31:30]]) void'(dq.pop_front());
      if (spi_val && e_spi_rdy) dq.push_back(spi_msg);
      if (pq.size() != 0) begin
        if (resp_rdy) begin
          rr = (int'(pq[0][31:30]) + 1) % N;
          void'(pq.pop_front());
        end
      end else if (found) begin
        e_resp = {2'(g), in_msg[g*PW +: PW]};
        pq.push_back(e_resp);
      end
      tick;
    end
    spi_val = 1'b0; in_val = '0; resp_rdy = 1'b1;

    // N_PORTS=3: address 3 is dropped but still handshaken
`ifdef SPI_ARB_DROP_CNT_EN
    exp_drop = 8'd255;
`else
    exp_drop = 8'd0;
`endif
    spi3_val = 1'b1;
    for (int c = 0; c < 300; c++) begin
      spi3_msg = {2'b11, 30'($urandom())};
      settle;
      chk("drop_spi_rdy", 64'(spi3_rdy), 64'd1);
      chk("drop_out_val", 64'(out3_val), 64'd0);
      tick;
    end
    spi3_val = 1'b0;
    settle;
    chk("drop_cnt", 64'(drop3_cnt), 64'(exp_drop));
    spi3_msg = {2'b10, 30'h55}; spi3_val = 1'b1;
    tick;
    spi3_val = 1'b0;
    settle;
    chk("n3_out_val", 64'(out3_val), 64'h4);
    chk("n3_payload", 64'(out3_msg[2*PW +: PW]), 64'h55);
    chk("n3_drop_hold", 64'(drop3_cnt), 64'(exp_drop));
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
